// File: rtl/apb_stream_uart_mc.sv
// rtl/apb_stream_uart_mc.sv - multi-channel 8N1 UART with APB registers and stream TX/RX ports
module apb_stream_uart_mc #(
  parameter int NCH        = 2,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  input  logic             PSEL,
  input  logic             PENABLE,
  input  logic             PWRITE,
  input  logic [7:0]       PADDR,
  input  logic [31:0]      PWDATA,
  input  logic [3:0]       PSTRB,
  output logic [31:0]      PRDATA,
  output logic             PREADY,
  output logic             PSLVERR,
  input  logic [NCH-1:0]   tx_tvalid,
  output logic [NCH-1:0]   tx_tready,
  input  logic [8*NCH-1:0] tx_tdata,
  output logic [NCH-1:0]   rx_tvalid,
  output logic [8*NCH-1:0] rx_tdata,
  output logic [NCH-1:0]   UART_TX,
  output logic [NCH-1:0]   UART_DE,
  output logic [NCH-1:0]   UART_RTS,
  output logic [NCH-1:0]   UART_DTR,
  input  logic [NCH-1:0]   UART_RX,
  output logic             irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  logic [3:0]     ch_idx;
  logic [3:0]     off;
  logic           bad_ch;
  logic           acc_wr;
  logic [31:0]    wmask;
  logic [31:0]    rd_data [NCH];
  logic [NCH-1:0] irq_src;
  logic           unused_bits;

  assign ch_idx      = PADDR[7:4];
  assign off         = PADDR[3:0];
  assign bad_ch      = ch_idx >= 4'(NCH);
  assign acc_wr      = PSEL & PENABLE & PWRITE & ~bad_ch;
  assign wmask       = {{8{PSTRB[3]}}, {8{PSTRB[2]}}, {8{PSTRB[1]}}, {8{PSTRB[0]}}};
  assign PREADY      = 1'b1;
  assign PSLVERR     = PRESETn & PSEL & PENABLE & bad_ch;
  assign irq         = |irq_src;
  assign unused_bits = ^{PWDATA, wmask};

  // Read mux: only an existing, addressed channel drives PRDATA
  always_comb begin
    PRDATA = '0;
    for (int i = 0; i < NCH; i++) begin
      if (PRESETn && PSEL && !PWRITE && ch_idx == 4'(i)) PRDATA = rd_data[i];
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [3:0]       ctrl_q, ctrl_d;
    logic [DIV_W-1:0] div_q, div_d, eff_div;
    logic             fe_q, fe_d, fe_set, wr_sel, push, pop;
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [AW-1:0]    wp_q, wp_d, rp_q, rp_d;
    logic [LW-1:0]    lvl_q, lvl_d;
    state_e           ts_q, ts_d, rs_q, rs_d;
    logic [DIV_W-1:0] tdiv_q, tdiv_d, tcnt_q, tcnt_d;
    logic [DIV_W-1:0] rdiv_q, rdiv_d, rcnt_q, rcnt_d, rhalf;
    logic [2:0]       tbit_q, tbit_d, rbit_q, rbit_d;
    logic [7:0]       tsh_q, tsh_d, rsh_q, rsh_d, rxd_q, rxd_d;
    logic             txo_q, txo_d, de_q, de_d, rxv_q, rxv_d;
    logic [2:0]       sync_q;

    assign wr_sel       = acc_wr && ch_idx == 4'(c);
    assign eff_div      = (div_q < DIV_W'(3)) ? DIV_W'(3) : div_q;
    assign rhalf        = (rdiv_q >> 1) + DIV_W'(rdiv_q[0]);
    assign tx_tready[c] = ctrl_q[0] && lvl_q != LW'(FIFO_DEPTH);
    assign push         = tx_tvalid[c] & tx_tready[c];
    assign UART_TX[c]   = txo_q;
    assign UART_DE[c]   = de_q;
    assign UART_RTS[c]  = ctrl_q[1];
    assign UART_DTR[c]  = ctrl_q[2];
    assign rx_tvalid[c] = rxv_q;
    assign rx_tdata[8*c +: 8] = rxd_q;
    assign irq_src[c]   = fe_q & ctrl_q[3];
    assign rd_data[c]   = (off == 4'h0) ? {28'd0, ctrl_q} :
                          (off == 4'h4) ? 32'(div_q) :
                          (off == 4'h8) ? ((32'(lvl_q) << 8) | {30'd0, fe_q, ts_q != S_IDLE}) : '0;

    // Register writes with byte-lane masking; FIFO level/pointers; FE set beats W1C clear
    always_comb begin
      ctrl_d = ctrl_q;
      div_d  = div_q;
      fe_d   = fe_q;
      if (wr_sel && off == 4'h0 && PSTRB[0]) ctrl_d = PWDATA[3:0];
      if (wr_sel && off == 4'h4)
        div_d = (div_q & ~wmask[DIV_W-1:0]) | (PWDATA[DIV_W-1:0] & wmask[DIV_W-1:0]);
      if (wr_sel && off == 4'h8 && PSTRB[0] && PWDATA[1]) fe_d = 1'b0;
      if (fe_set) fe_d = 1'b1;
      lvl_d = ~ctrl_d[0] ? '0 : lvl_q + LW'(push) - LW'(pop);
      wp_d  = ~ctrl_d[0] ? '0 : wp_q + AW'(push);
      rp_d  = ~ctrl_d[0] ? '0 : rp_q + AW'(pop);
    end

    // TX FSM next state: a frame start pops the FIFO and latches the divisor
    always_comb begin
      ts_d   = ts_q;
      tcnt_d = tcnt_q;
      tbit_d = tbit_q;
      tsh_d  = tsh_q;
      tdiv_d = tdiv_q;
      pop    = 1'b0;
      case (ts_q)
        S_IDLE:  pop = (lvl_q != '0);
        S_START: if (tcnt_q == tdiv_q) begin
                   ts_d = S_DATA; tbit_d = '0; tcnt_d = '0;
                 end else tcnt_d = tcnt_q + DIV_W'(1);
        S_DATA:  if (tcnt_q == tdiv_q) begin
                   tcnt_d = '0; tsh_d = tsh_q >> 1; tbit_d = tbit_q + 3'd1;
                   if (tbit_q == 3'd7) ts_d = S_STOP;
                 end else tcnt_d = tcnt_q + DIV_W'(1);
        default: if (tcnt_q == tdiv_q) begin
                   ts_d = S_IDLE; pop = (lvl_q != '0);
                 end else tcnt_d = tcnt_q + DIV_W'(1);
      endcase
      if (pop) begin
        ts_d = S_START; tcnt_d = '0; tsh_d = mem_q[rp_q]; tdiv_d = eff_div;
      end
      txo_d = (ts_q == S_START) ? 1'b0 : (ts_q == S_DATA) ? tsh_q[0] : 1'b1;
      de_d  = (ts_q != S_IDLE);
    end

    // RX FSM next state: start on a synchronised falling edge, sample mid-bit
    always_comb begin
      rs_d   = rs_q;
      rcnt_d = rcnt_q;
      rbit_d = rbit_q;
      rsh_d  = rsh_q;
      rdiv_d = rdiv_q;
      rxd_d  = rxd_q;
      rxv_d  = 1'b0;
      fe_set = 1'b0;
      if (rs_q != S_IDLE) rcnt_d = (rcnt_q == rdiv_q) ? '0 : rcnt_q + DIV_W'(1);
      case (rs_q)
        S_IDLE:  if (ctrl_q[0] && sync_q[2] && !sync_q[1]) begin
                   rs_d = S_START; rcnt_d = '0; rdiv_d = eff_div;
                 end
        S_START: if (rcnt_q == rhalf && sync_q[1]) rs_d = S_IDLE;
                 else if (rcnt_q == rdiv_q) begin
                   rs_d = S_DATA; rbit_d = '0;
                 end
        S_DATA:  begin
                   if (rcnt_q == rhalf) rsh_d = {sync_q[1], rsh_q[7:1]};
                   if (rcnt_q == rdiv_q) begin
                     rbit_d = rbit_q + 3'd1;
                     if (rbit_q == 3'd7) rs_d = S_STOP;
                   end
                 end
        default: if (rcnt_q == rhalf) begin
                   rs_d = S_IDLE;
                   if (sync_q[1]) begin
                     rxv_d = 1'b1; rxd_d = rsh_q;
                   end else fe_set = 1'b1;
                 end
      endcase
    end

    // FIFO storage; contents are qualified by the level so no reset is needed
    always_ff @(posedge PCLK) begin
      if (push) mem_q[wp_q] <= tx_tdata[8*c +: 8];
    end

    // Channel state registers; reset aborts any frame and idles the line high
    always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
        ctrl_q <= '0;     div_q  <= DIV_W'('h363); fe_q  <= 1'b0;
        wp_q   <= '0;     rp_q   <= '0;            lvl_q <= '0;
        ts_q   <= S_IDLE; tcnt_q <= '0;  tbit_q <= '0; tsh_q <= '0; tdiv_q <= '0;
        txo_q  <= 1'b1;   de_q   <= 1'b0;
        rs_q   <= S_IDLE; rcnt_q <= '0;  rbit_q <= '0; rsh_q <= '0; rdiv_q <= '0;
        rxd_q  <= '0;     rxv_q  <= 1'b0; sync_q <= 3'b111;
      end else begin
        ctrl_q <= ctrl_d; div_q  <= div_d;  fe_q  <= fe_d;
        wp_q   <= wp_d;   rp_q   <= rp_d;   lvl_q <= lvl_d;
        ts_q   <= ts_d;   tcnt_q <= tcnt_d; tbit_q <= tbit_d; tsh_q <= tsh_d; tdiv_q <= tdiv_d;
        txo_q  <= txo_d;  de_q   <= de_d;
        rs_q   <= rs_d;   rcnt_q <= rcnt_d; rbit_q <= rbit_d; rsh_q <= rsh_d; rdiv_q <= rdiv_d;
        rxd_q  <= rxd_d;  rxv_q  <= rxv_d;  sync_q <= {sync_q[1:0], UART_RX[c]};
      end
    end
  end
endmodule

// File: tb/tb_apb_stream_uart_mc.sv
// tb/tb_apb_stream_uart_mc.sv - directed self-checking bench for apb_stream_uart_mc
module tb_apb_stream_uart_mc;
  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        PSEL, PENABLE, PWRITE;
  logic [7:0]  PADDR;
  logic [31:0] PWDATA, PRDATA;
  logic [3:0]  PSTRB;
  logic        PREADY, PSLVERR, irq;
  logic [1:0]  tx_tvalid, tx_tready, rx_tvalid;
  logic [15:0] tx_tdata, rx_tdata;
  logic [1:0]  UART_TX, UART_DE, UART_RTS, UART_DTR, UART_RX;
  logic        rx0;
  int          n_pass = 0;
  int          n_total = 0;
  logic [31:0] rd;
  logic        err;

  assign UART_RX = {UART_TX[1], rx0};

  always #5 PCLK = ~PCLK;

  apb_stream_uart_mc #(.NCH(2), .FIFO_DEPTH(16), .DIV_W(16)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR), .tx_tvalid(tx_tvalid), .tx_tready(tx_tready), .tx_tdata(tx_tdata),
    .rx_tvalid(rx_tvalid), .rx_tdata(rx_tdata), .UART_TX(UART_TX), .UART_DE(UART_DE),
    .UART_RTS(UART_RTS), .UART_DTR(UART_DTR), .UART_RX(UART_RX), .irq(irq)
  );

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic apb_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic e);
    @(negedge PCLK); PSEL = 1'b1; PWRITE = 1'b1; PADDR = a; PWDATA = d; PSTRB = s; PENABLE = 1'b0;
    @(negedge PCLK); PENABLE = 1'b1; #1 e = PSLVERR;
    @(negedge PCLK); PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [7:0] a, output logic [31:0] d, output logic e);
    @(negedge PCLK); PSEL = 1'b1; PWRITE = 1'b0; PADDR = a; PENABLE = 1'b0;
    @(negedge PCLK); PENABLE = 1'b1; #1 d = PRDATA; e = PSLVERR;
    @(negedge PCLK); PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic push(input int ch, input logic [7:0] d);
    @(negedge PCLK); tx_tvalid[ch] = 1'b1; tx_tdata[8*ch +: 8] = d;
    @(negedge PCLK); tx_tvalid[ch] = 1'b0;
  endtask

  task automatic test_reset;
    n_total++; if ({UART_TX, UART_DE} !== 4'b1100) $display("FAIL reset_line: got %b required 1100", {UART_TX, UART_DE});
    else n_pass++;
    n_total++; if ({tx_tready, rx_tvalid, irq, PREADY} !== 6'b000001) $display("FAIL reset_misc: got %b required 000001", {tx_tready, rx_tvalid, irq, PREADY});
    else n_pass++;
    apb_read(8'h04, rd, err);
    n_total++; if (rd !== 32'h363) $display("FAIL reset_baud: got %h required 00000363", rd);
    else n_pass++;
    apb_read(8'h08, rd, err);
    n_total++; if (rd !== 32'h0) $display("FAIL reset_status: got %h required 00000000", rd);
    else n_pass++;
  endtask

  task automatic test_tx_frame;
    logic [111:0] got_tx, got_de, exp_tx, exp_de;
    logic [7:0]   b;
    int           bi;
    b = 8'hA5;
    apb_write(8'h00, 32'h1, 4'hF, err);
    apb_write(8'h04, 32'd9, 4'hF, err);
    n_total++; if (tx_tready[0] !== 1'b1) $display("FAIL tx_tready_en: got %b required 1", tx_tready[0]);
    else n_pass++;
    push(0, b);
    for (int i = 0; i < 112; i++) begin
      if (i > 0) @(negedge PCLK);
      got_tx[i] = UART_TX[0];
      got_de[i] = UART_DE[0];
      if (i < 2 || i >= 102) exp_tx[i] = 1'b1;
      else begin
        bi = (i - 2) / 10;
        exp_tx[i] = (bi == 0) ? 1'b0 : (bi == 9) ? 1'b1 : b[bi-1];
      end
      exp_de[i] = (i >= 2 && i < 102);
    end
    n_total++; if (got_tx !== exp_tx) $display("FAIL tx_waveform: got %h required %h", got_tx, exp_tx);
    else n_pass++;
    n_total++; if (got_de !== exp_de) $display("FAIL de_waveform: got %h required %h", got_de, exp_de);
    else n_pass++;
  endtask

  task automatic test_fifo_full;
    apb_write(8'h04, 32'd1000, 4'hF, err);
    @(negedge PCLK); tx_tvalid[0] = 1'b1;
    for (int k = 0; k < 16; k++) begin
      tx_tdata[7:0] = 8'(k);
      @(negedge PCLK);
    end
    tx_tvalid[0] = 1'b0;
    n_total++; if (tx_tready[0] !== 1'b1) $display("FAIL fifo_ready_at_15: got %b required 1", tx_tready[0]);
    else n_pass++;
    apb_read(8'h08, rd, err);
    n_total++; if (rd !== 32'h0F01) $display("FAIL fifo_level_15: got %h required 00000f01", rd);
    else n_pass++;
    push(0, 8'h10);
    n_total++; if (tx_tready[0] !== 1'b0) $display("FAIL fifo_full_ready: got %b required 0", tx_tready[0]);
    else n_pass++;
    push(0, 8'h11);
    apb_read(8'h08, rd, err);
    n_total++; if (rd !== 32'h1001) $display("FAIL fifo_level_16: got %h required 00001001", rd);
    else n_pass++;
  endtask

  task automatic test_en_clear;
    int waited;
    apb_write(8'h00, 32'h0, 4'hF, err);
    apb_read(8'h08, rd, err);
    n_total++; if (rd !== 32'h1) $display("FAIL flush_level: got %h required 00000001", rd);
    else n_pass++;
    waited = 0;
    while (UART_DE[0] === 1'b1 && waited < 12000) begin
      @(negedge PCLK); waited++;
    end
    n_total++; if (UART_DE[0] !== 1'b0) $display("FAIL frame_complete: got DE %b required 0 within bound", UART_DE[0]);
    else n_pass++;
    n_total++; if (waited < 9000) $display("FAIL frame_not_cut: got %0d cycles required >= 9000", waited);
    else n_pass++;
    repeat (30) @(negedge PCLK);
    apb_read(8'h08, rd, err);
    n_total++; if ({rd, UART_DE[0], UART_TX[0]} !== {32'h0, 1'b0, 1'b1}) $display("FAIL after_flush: got status %h de %b tx %b required 0 0 1", rd, UART_DE[0], UART_TX[0]);
    else n_pass++;
  endtask

  task automatic test_frame_error;
    logic [9:0] fr;
    int         pulses;
    fr = {1'b0, 8'h55, 1'b0};
    pulses = 0;
    apb_write(8'h00, 32'h9, 4'hF, err);
    apb_write(8'h04, 32'd9, 4'hF, err);
    for (int b = 0; b < 10; b++) begin
      for (int k = 0; k < 10; k++) begin
        @(negedge PCLK); rx0 = fr[b];
        if (rx_tvalid[0]) pulses++;
      end
    end
    for (int k = 0; k < 30; k++) begin
      @(negedge PCLK); rx0 = 1'b1;
      if (rx_tvalid[0]) pulses++;
    end
    n_total++; if (pulses !== 0) $display("FAIL fe_no_strobe: got %0d pulses required 0", pulses);
    else n_pass++;
    n_total++; if (irq !== 1'b1) $display("FAIL fe_irq: got %b required 1", irq);
    else n_pass++;
    apb_read(8'h08, rd, err);
    n_total++; if (rd !== 32'h2) $display("FAIL fe_status: got %h required 00000002", rd);
    else n_pass++;
    apb_write(8'h08, 32'h2, 4'h1, err);
    n_total++; if (irq !== 1'b0) $display("FAIL fe_w1c_irq: got %b required 0", irq);
    else n_pass++;
    apb_read(8'h08, rd, err);
    n_total++; if (rd !== 32'h0) $display("FAIL fe_w1c_status: got %h required 00000000", rd);
    else n_pass++;
  endtask

  task automatic test_loopback;
    int          high_cycles;
    logic [7:0]  cap;
    high_cycles = 0;
    cap = 8'h00;
    apb_write(8'h10, 32'h7, 4'hF, err);
    apb_write(8'h14, 32'd9, 4'hF, err);
    n_total++; if ({UART_RTS, UART_DTR} !== 4'b1010) $display("FAIL rts_dtr: got %b required 1010", {UART_RTS, UART_DTR});
    else n_pass++;
    push(1, 8'h3C);
    for (int k = 0; k < 200; k++) begin
      @(negedge PCLK);
      if (rx_tvalid[1]) begin
        high_cycles++;
        cap = rx_tdata[15:8];
      end
    end
    n_total++; if (high_cycles !== 1) $display("FAIL loop_pulse: got %0d strobe cycles required 1", high_cycles);
    else n_pass++;
    n_total++; if (cap !== 8'h3C) $display("FAIL loop_data: got %h required 3c", cap);
    else n_pass++;
    n_total++; if (rx_tdata[15:8] !== 8'h3C) $display("FAIL loop_hold: got %h required 3c", rx_tdata[15:8]);
    else n_pass++;
    apb_read(8'h18, rd, err);
    n_total++; if (rd !== 32'h0) $display("FAIL loop_status: got %h required 00000000", rd);
    else n_pass++;
  endtask

  task automatic test_pslverr_strobe;
    apb_write(8'h20, 32'hF, 4'hF, err);
    n_total++; if (err !== 1'b1) $display("FAIL slverr_write: got %b required 1", err);
    else n_pass++;
    apb_read(8'h00, rd, err);
    n_total++; if (rd !== 32'h9) $display("FAIL slverr_no_change: got %h required 00000009", rd);
    else n_pass++;
    apb_read(8'h20, rd, err);
    n_total++; if ({err, rd} !== {1'b1, 32'h0}) $display("FAIL slverr_read: got err %b data %h required 1 00000000", err, rd);
    else n_pass++;
    apb_write(8'h14, 32'h0000ABCD, 4'b0010, err);
    n_total++; if (err !== 1'b0) $display("FAIL ok_write_err: got %b required 0", err);
    else n_pass++;
    apb_read(8'h14, rd, err);
    n_total++; if (rd !== 32'hAB09) $display("FAIL strobe_baud: got %h required 0000ab09", rd);
    else n_pass++;
  endtask

  task automatic test_reset_midframe;
    apb_write(8'h00, 32'h1, 4'hF, err);
    push(0, 8'h00);
    repeat (40) @(negedge PCLK);
    n_total++; if ({UART_TX[0], UART_DE[0]} !== 2'b01) $display("FAIL midframe_pre: got %b required 01", {UART_TX[0], UART_DE[0]});
    else n_pass++;
    #2 PRESETn = 1'b0;
    #1;
    n_total++; if ({UART_TX, UART_DE, UART_RTS} !== 6'b110000) $display("FAIL async_reset_line: got %b required 110000", {UART_TX, UART_DE, UART_RTS});
    else n_pass++;
    n_total++; if ({rx_tdata, tx_tready, irq} !== 19'h0) $display("FAIL async_reset_misc: got %h required 0", {rx_tdata, tx_tready, irq});
    else n_pass++;
    @(negedge PCLK); PRESETn = 1'b1;
    apb_read(8'h00, rd, err);
    n_total++; if (rd !== 32'h0) $display("FAIL post_reset_ctrl: got %h required 00000000", rd);
    else n_pass++;
    apb_read(8'h04, rd, err);
    n_total++; if (rd !== 32'h363) $display("FAIL post_reset_baud: got %h required 00000363", rd);
    else n_pass++;
    apb_read(8'h08, rd, err);
    n_total++; if (rd !== 32'h0) $display("FAIL post_reset_status: got %h required 00000000", rd);
    else n_pass++;
  endtask

  initial begin
    PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0; PSTRB = '0;
    tx_tvalid = '0; tx_tdata = '0; rx0 = 1'b1;
    repeat (3) @(negedge PCLK);
    PRESETn = 1'b1;
    @(negedge PCLK);
    test_reset;
    test_tx_frame;
    test_fifo_full;
    test_en_clear;
    test_frame_error;
    test_loopback;
    test_pslverr_strobe;
    test_reset_midframe;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
